// File: rtl/seq_arith_unit.sv
// ============================================================================
// Module      : seq_arith_unit
// Description : Multi-cycle ADD/SUB/MUL/DIV unit with start/busy/done handshake
//               and a 2W-bit registered result with status flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_arith_unit #(
    parameter int W = 8
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           start,
    input  logic [1:0]     op,
    input  logic           sgn,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] result,
    output logic           ovf,
    output logic           neg,
    output logic           zero,
    output logic           dz
);

    localparam int         c_CW     = $clog2(W + 1);
    localparam logic [1:0] c_OP_ADD = 2'b00;
    localparam logic [1:0] c_OP_SUB = 2'b01;
    localparam logic [1:0] c_OP_MUL = 2'b10;
    localparam logic [1:0] c_OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [c_CW-1:0]  r_cnt;
    logic [1:0]       r_op;
    logic             r_sgn;
    logic [W-1:0]     r_a, r_b, r_bmag;
    logic [2*W:0]     r_acc;
    logic [2*W-1:0]   r_result;
    logic             r_ovf, r_neg, r_zero, r_dz;

    logic             w_accept, w_last;
    logic [W-1:0]     w_amag, w_bmag;
    logic [W:0]       w_mul_sum, w_div_sh, w_div_diff, w_addsub;
    logic             w_div_ok;
    logic [2*W:0]     w_acc_nxt;
    logic [W-1:0]     w_s, w_q_fix, w_r_fix;
    logic [2*W-1:0]   w_prod_fix, w_res;
    logic             w_sa, w_sb, w_sovf, w_dz, w_ovf, w_msb, w_zero;

    assign w_accept = start && (r_state != S_RUN);
    assign w_last   = (r_state == S_RUN) && (r_cnt == c_CW'(1));

    always_ff @(posedge CLK) begin
        if (RST) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_RUN;
            S_RUN:   if (r_cnt == c_CW'(1)) w_state_nxt = S_FIN;
            S_FIN:   w_state_nxt = start ? S_RUN : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // MUL and DIV iterate on operand magnitudes; signs are restored at the end
    assign w_amag = (sgn && a[W-1]) ? -a : a;
    assign w_bmag = (sgn && b[W-1]) ? -b : b;

    // Shift-add step: bit 0 of the accumulator is the current multiplier bit
    assign w_mul_sum = r_acc[2*W:W] + (r_acc[0] ? {1'b0, r_bmag} : '0);
    // Restoring step: partial remainder in the high half, quotient shifts in low
    assign w_div_sh   = {r_acc[2*W-1:W], r_acc[W-1]};
    assign w_div_diff = w_div_sh - {1'b0, r_bmag};
    assign w_div_ok   = ~w_div_diff[W];
    assign w_acc_nxt  = (r_op == c_OP_DIV)
                      ? {1'b0, (w_div_ok ? w_div_diff[W-1:0] : w_div_sh[W-1:0]),
                         r_acc[W-2:0], w_div_ok}
                      : {1'b0, w_mul_sum, r_acc[W-1:1]};

    assign w_sa     = r_a[W-1];
    assign w_sb     = r_b[W-1];
    assign w_addsub = (r_op == c_OP_SUB) ? ({1'b0, r_a} - {1'b0, r_b})
                                         : ({1'b0, r_a} + {1'b0, r_b});
    assign w_s      = w_addsub[W-1:0];
    assign w_sovf   = ((r_op == c_OP_SUB) ? (w_sa != w_sb) : (w_sa == w_sb))
                      && (w_s[W-1] != w_sa);
    assign w_prod_fix = (r_sgn && (w_sa ^ w_sb)) ? -w_acc_nxt[2*W-1:0]
                                                 : w_acc_nxt[2*W-1:0];
    assign w_q_fix  = (r_sgn && (w_sa ^ w_sb)) ? -w_acc_nxt[W-1:0] : w_acc_nxt[W-1:0];
    assign w_r_fix  = (r_sgn && w_sa) ? -w_acc_nxt[2*W-1:W] : w_acc_nxt[2*W-1:W];
    assign w_dz     = (r_op == c_OP_DIV) && (r_b == '0);

    always_comb begin
        w_res  = '0;
        w_ovf  = 1'b0;
        w_msb  = 1'b0;
        w_zero = 1'b0;
        case (r_op)
            c_OP_ADD, c_OP_SUB: begin
                w_res  = r_sgn ? {{W{w_s[W-1]}}, w_s} : {{W{1'b0}}, w_s};
                w_ovf  = r_sgn ? w_sovf : w_addsub[W];
                w_msb  = w_s[W-1];
                w_zero = (w_s == '0);
            end
            c_OP_MUL: begin
                w_res  = w_prod_fix;
                w_msb  = w_prod_fix[2*W-1];
                w_zero = (w_prod_fix == '0);
            end
            default: begin
                if (w_dz) begin
                    w_res = {r_a, {W{1'b1}}};
                    w_msb = 1'b1;
                end else begin
                    w_res  = {w_r_fix, w_q_fix};
                    w_ovf  = r_sgn && (r_a == {1'b1, {(W-1){1'b0}}}) && (r_b == '1);
                    w_msb  = w_q_fix[W-1];
                    w_zero = (w_q_fix == '0);
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt    <= '0;
            r_op     <= '0;
            r_sgn    <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_bmag   <= '0;
            r_acc    <= '0;
            r_result <= '0;
            r_ovf    <= 1'b0;
            r_neg    <= 1'b0;
            r_zero   <= 1'b0;
            r_dz     <= 1'b0;
        end else if (w_accept) begin
            r_op   <= op;
            r_sgn  <= sgn;
            r_a    <= a;
            r_b    <= b;
            r_bmag <= w_bmag;
            r_acc  <= {{(W+1){1'b0}}, w_amag};
            r_cnt  <= ((op == c_OP_ADD) || (op == c_OP_SUB) ||
                       ((op == c_OP_DIV) && (b == '0))) ? c_CW'(1) : c_CW'(W);
        end else if (r_state == S_RUN) begin
            r_cnt <= r_cnt - c_CW'(1);
            r_acc <= w_acc_nxt;
            if (w_last) begin
                r_result <= w_res;
                r_ovf    <= w_ovf;
                r_neg    <= r_sgn & w_msb;
                r_zero   <= w_zero;
                r_dz     <= w_dz;
            end
        end
    end

    assign busy   = (r_state == S_RUN);
    assign done   = (r_state == S_FIN);
    assign result = r_result;
    assign ovf    = r_ovf;
    assign neg    = r_neg;
    assign zero   = r_zero;
    assign dz     = r_dz;

endmodule

`default_nettype wire

// File: tb/tb_seq_arith_unit.sv
// ============================================================================
// Module      : tb_seq_arith_unit
// Description : Table-driven scoreboard bench for seq_arith_unit (W=8).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_arith_unit;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef struct {
        logic [1:0]  op;
        logic        sgn;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] res;
        logic        ovf;
        logic        neg;
        logic        zero;
        logic        dz;
        int          lat;
    } vec_t;

    typedef struct {
        vec_t v;
        int   t0;
        int   idx;
    } exp_t;

    logic        CLK, RST, start, sgn;
    logic [1:0]  op;
    logic [7:0]  a, b;
    logic        busy, done, ovf, neg, zero, dz;
    logic [15:0] result;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    exp_t exp_q[$];
    exp_t m_e;
    vec_t tbl[18];

    seq_arith_unit #(.W(8)) dut (
        .CLK(CLK), .RST(RST), .start(start), .op(op), .sgn(sgn), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .ovf(ovf), .neg(neg),
        .zero(zero), .dz(dz)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest outstanding request
    always @(negedge CLK) begin
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                m_e = exp_q.pop_front();
                chk($sformatf("v%0d_result", m_e.idx), 32'(result), 32'(m_e.v.res));
                chk($sformatf("v%0d_ovf", m_e.idx), 32'(ovf), 32'(m_e.v.ovf));
                chk($sformatf("v%0d_neg", m_e.idx), 32'(neg), 32'(m_e.v.neg));
                chk($sformatf("v%0d_zero", m_e.idx), 32'(zero), 32'(m_e.v.zero));
                chk($sformatf("v%0d_dz", m_e.idx), 32'(dz), 32'(m_e.v.dz));
                chk($sformatf("v%0d_latency", m_e.idx), 32'(cyc - m_e.t0), 32'(m_e.v.lat + 1));
                chk($sformatf("v%0d_busy_at_done", m_e.idx), 32'(busy), 32'd0);
            end
        end
    end

    task automatic push_exp(input vec_t v, input int idx);
        exp_t e;
        e.v   = v;
        e.t0  = cyc;
        e.idx = idx;
        exp_q.push_back(e);
    endtask

    task automatic drive(input vec_t v);
        start = 1'b1;
        op    = v.op;
        sgn   = v.sgn;
        a     = v.a;
        b     = v.b;
    endtask

    task automatic wait_drain(input int idx);
        int t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(negedge CLK);
            t++;
        end
        if (exp_q.size() != 0) begin
            chk($sformatf("v%0d_timeout", idx), 32'd1, 32'd0);
            exp_q.delete();
        end
    endtask

    task automatic issue(input vec_t v, input int idx);
        @(negedge CLK);
        drive(v);
        push_exp(v, idx);
        @(posedge CLK);
        #1;
        start = 1'b0;
        a     = 8'($urandom);
        b     = 8'($urandom);
        @(negedge CLK);
        chk($sformatf("v%0d_busy_c1", idx), 32'(busy), 32'd1);
        wait_drain(idx);
    endtask

    initial begin
        vec_t v;
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        //           op      sgn  a      b      res       ovf neg zro dz  lat
        tbl[0]  = '{OP_ADD, 1'b1, 8'd100, 8'd50, 16'hFF96, 1'b1, 1'b1, 1'b0, 1'b0, 1};
        tbl[1]  = '{OP_ADD, 1'b0, 8'd200, 8'd100, 16'h002C, 1'b1, 1'b0, 1'b0, 1'b0, 1};
        tbl[2]  = '{OP_SUB, 1'b0, 8'd5,   8'd5,   16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1};
        tbl[3]  = '{OP_MUL, 1'b1, 8'hFD,  8'd7,   16'hFFEB, 1'b0, 1'b1, 1'b0, 1'b0, 8};
        tbl[4]  = '{OP_MUL, 1'b0, 8'hFF,  8'hFF,  16'hFE01, 1'b0, 1'b0, 1'b0, 1'b0, 8};
        tbl[5]  = '{OP_DIV, 1'b0, 8'd200, 8'd7,   16'h041C, 1'b0, 1'b0, 1'b0, 1'b0, 8};
        tbl[6]  = '{OP_DIV, 1'b1, 8'hF9,  8'd2,   16'hFFFD, 1'b0, 1'b1, 1'b0, 1'b0, 8};
        tbl[7]  = '{OP_DIV, 1'b1, 8'h80,  8'hFF,  16'h0080, 1'b1, 1'b1, 1'b0, 1'b0, 8};
        tbl[8]  = '{OP_DIV, 1'b0, 8'h55,  8'h00,  16'h55FF, 1'b0, 1'b0, 1'b0, 1'b1, 1};
        tbl[9]  = '{OP_ADD, 1'b0, 8'd1,   8'd1,   16'h0002, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        tbl[10] = '{OP_MUL, 1'b1, 8'h80,  8'h80,  16'h4000, 1'b0, 1'b0, 1'b0, 1'b0, 8};
        tbl[11] = '{OP_SUB, 1'b1, 8'h80,  8'h01,  16'h007F, 1'b1, 1'b0, 1'b0, 1'b0, 1};
        tbl[12] = '{OP_SUB, 1'b0, 8'd3,   8'd5,   16'h00FE, 1'b1, 1'b0, 1'b0, 1'b0, 1};
        tbl[13] = '{OP_DIV, 1'b1, 8'd7,   8'hFE,  16'h01FD, 1'b0, 1'b1, 1'b0, 1'b0, 8};
        tbl[14] = '{OP_MUL, 1'b1, 8'h00,  8'h85,  16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 8};
        tbl[15] = '{OP_DIV, 1'b1, 8'hF9,  8'h00,  16'hF9FF, 1'b0, 1'b1, 1'b0, 1'b1, 1};
        tbl[16] = '{OP_ADD, 1'b1, 8'h7F,  8'h01,  16'hFF80, 1'b1, 1'b1, 1'b0, 1'b0, 1};
        tbl[17] = '{OP_DIV, 1'b0, 8'd0,   8'd5,   16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 8};

        RST = 1'b1; start = 1'b0; op = OP_ADD; sgn = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_flags", 32'({ovf, neg, zero, dz}), 32'd0);

        for (int i = 0; i < 18; i++) issue(tbl[i], i);

        // Second start during a MUL is ignored; original product must come back
        v = tbl[3];
        @(negedge CLK);
        drive(v);
        push_exp(v, 100);
        @(posedge CLK); #1 start = 1'b0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        start = 1'b1; op = OP_ADD; a = 8'd5; b = 8'd5;
        @(posedge CLK); #1 start = 1'b0;
        wait_drain(100);

        // Reset in cycle 4 of a MUL aborts it without a done pulse
        v = '{OP_MUL, 1'b0, 8'd12, 8'd11, 16'h0084, 1'b0, 1'b0, 1'b0, 1'b0, 8};
        @(negedge CLK);
        drive(v);
        @(posedge CLK); #1 start = 1'b0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("abort_busy_c3", 32'(busy), 32'd1);
        @(posedge CLK); #1 RST = 1'b1;
        @(posedge CLK); #1 RST = 1'b0;
        @(negedge CLK);
        chk("abort_busy_c5", 32'(busy), 32'd0);
        chk("abort_result", 32'(result), 32'd0);
        repeat (12) @(negedge CLK);
        chk("abort_result_late", 32'(result), 32'd0);

        // Back-to-back: start held high through FIN accepts the second op there
        v = '{OP_ADD, 1'b0, 8'd3, 8'd4, 16'h0007, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        @(negedge CLK);
        drive(v);
        push_exp(v, 200);
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        chk("b2b_done_fin", 32'(done), 32'd1);
        v = '{OP_ADD, 1'b0, 8'd10, 8'd20, 16'h001E, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        drive(v);
        push_exp(v, 201);
        @(posedge CLK); #1 start = 1'b0;
        chk("b2b_busy_next", 32'(busy), 32'd1);
        wait_drain(201);

        repeat (3) @(negedge CLK);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
